// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: data width, opcode encoding and status-flag layout.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } opcode_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and next-state flags from a, b and opcode.
// The flags port and the carry path exist only when ALU_FLAGS_EN is defined.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        opcode_i,
    output logic [DATA_W-1:0] result_o
`ifdef ALU_FLAGS_EN
    ,
    output flags_t            flags_o
`endif
);

    opcode_e           op;
    logic              is_logic;
    logic              sub_op;
    logic              use_one;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] arith;
    logic [DATA_W-1:0] logic_res;

    assign op       = opcode_e'(opcode_i);
    assign is_logic = opcode_i[2];
    assign sub_op   = (op == OP_SUB) || (op == OP_DEC);
    assign use_one  = (op == OP_INC) || (op == OP_DEC);
    // INC/DEC reuse the add/subtract path with a constant second operand.
    assign opnd     = use_one ? {{(DATA_W-1){1'b0}}, 1'b1} : b_i;

`ifdef ALU_FLAGS_EN
    logic [DATA_W:0] wide;
    logic            carry;

    assign wide  = sub_op ? ({1'b0, a_i} - {1'b0, opnd}) : ({1'b0, a_i} + {1'b0, opnd});
    assign arith = wide[DATA_W-1:0];
    assign carry = wide[DATA_W];
`else
    assign arith = sub_op ? (a_i - opnd) : (a_i + opnd);
`endif

    always_comb begin
        logic_res = '0;
        case (op)
            OP_AND:  logic_res = a_i & b_i;
            OP_OR:   logic_res = a_i | b_i;
            OP_XOR:  logic_res = a_i ^ b_i;
            OP_NOT:  logic_res = ~a_i;
            default: logic_res = '0;
        endcase
    end

    assign result_o = is_logic ? logic_res : arith;

`ifdef ALU_FLAGS_EN
    // Overflow: sign test on a and the effective second operand, then result sign vs a.
    assign flags_o.z = (result_o == '0);
    assign flags_o.n = result_o[DATA_W-1];
    assign flags_o.c = !is_logic && carry;
    assign flags_o.v = !is_logic
                       && (sub_op ? (a_i[DATA_W-1] != opnd[DATA_W-1])
                                  : (a_i[DATA_W-1] == opnd[DATA_W-1]))
                       && (arith[DATA_W-1] != a_i[DATA_W-1]);
`endif

endmodule

// File: rtl/alu.sv
// Registered 16-bit ALU top: one-cycle latency, valid-qualified output registers.
// Define ALU_FLAGS_EN to build the z/c/n/v flag registers; otherwise the flags are tied to 0.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [0:15] a,
    input  logic [0:15] b,
    input  logic [0:2]  opcode,
    output logic [0:15] out,
    output logic        out_valid,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_n,
    output logic        flag_v
);

    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;
    logic              out_valid_q;

`ifdef ALU_FLAGS_EN
    flags_t flags_d;
    flags_t flags_q;
`endif

    alu_core u_core (
        .a_i      (a),
        .b_i      (b),
        .opcode_i (opcode),
        .result_o (out_d)
`ifdef ALU_FLAGS_EN
        ,
        .flags_o  (flags_d)
`endif
    );

    // Result holds when no operation is accepted; valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q <= out_d;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (in_valid) begin
            flags_q <= flags_d;
        end
    end

    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_n = flags_q.n;
    assign flag_v = flags_q.v;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, hold/reset behaviour and a randomized stream.
// Flag expectations follow ALU_FLAGS_EN (all zero when the macro is undefined).
module tb_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [0:15] a;
    logic [0:15] b;
    logic [0:2]  opcode;
    logic [0:15] out;
    logic        out_valid;
    logic        flag_z;
    logic        flag_c;
    logic        flag_n;
    logic        flag_v;

    int n_checks;
    int n_fail;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out       (out),
        .out_valid (out_valid),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] flags_mask(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
        return f;
`else
        return 4'b0000 & f;
`endif
    endfunction

    // Reference model in plain integer arithmetic; flags returned as {z,c,n,v}.
    function automatic void model(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, full, sfull;
        bit c, v;
        ua = av; ub = bv;
        sa = $signed(av); sb = $signed(bv);
        c = 0; v = 0; full = 0; sfull = 0;
        case (op)
            3'd0: begin full = ua + ub; c = (full > 65535); sfull = sa + sb; end
            3'd1: begin full = ua - ub; c = (ua < ub);      sfull = sa - sb; end
            3'd2: begin full = ua + 1;  c = (full > 65535); sfull = sa + 1;  end
            3'd3: begin full = ua - 1;  c = (ua == 0);      sfull = sa - 1;  end
            3'd4: full = ua & ub;
            3'd5: full = ua | ub;
            3'd6: full = ua ^ ub;
            default: full = (~ua) & 32'hFFFF;
        endcase
        if (op < 3'd4) v = (sfull > 32767) || (sfull < -32768);
        r = full[15:0];
        f = flags_mask({r == 16'h0000, c, r[15], v});
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        in_valid = v;
        opcode   = op;
        a        = av;
        b        = bv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 16'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h want 0000", out); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++;
        if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {flag_z, flag_c, flag_n, flag_v});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed vectors with hand-derived results, applied back to back.
    task automatic test_directed();
        logic [2:0]  ops  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd2, 3'd3, 3'd1};
        logic [15:0] avs  [12] = '{16'd64, 16'd64, 16'd64, 16'd64, 16'h03FF, 16'h003F, 16'h1C3F, 16'h1F87,
                                   16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
        logic [15:0] bvs  [12] = '{16'd32, 16'd32, 16'd0, 16'd0, 16'hFFC0, 16'hFC00, 16'hFC38, 16'h0000,
                                   16'h0001, 16'h0000, 16'h0000, 16'h0001};
        logic [15:0] exps [12] = '{16'd96, 16'd32, 16'd65, 16'd63, 16'h03C0, 16'hFC3F, 16'hE007, 16'hE078,
                                   16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
        logic [3:0]  expf [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010,
                                   4'b1100, 4'b0011, 4'b0110, 4'b0001};
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, ops[i], avs[i], bvs[i]);
            @(posedge clk); #1;
            n_checks++;
            if (out !== exps[i]) begin n_fail++; $display("FAIL dir%0d_out: got %h want %h", i, out, exps[i]); end
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b want 1", i, out_valid); end
            n_checks++;
            if ({flag_z, flag_c, flag_n, flag_v} !== flags_mask(expf[i])) begin
                n_fail++;
                $display("FAIL dir%0d_flags: got %b want %b", i, {flag_z, flag_c, flag_n, flag_v}, flags_mask(expf[i]));
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 3'd0, 16'd64, 16'd32);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 3'd1, 16'hAAAA, 16'h1234);
            @(posedge clk); #1;
            n_checks++;
            if (out !== 16'd96) begin n_fail++; $display("FAIL hold%0d_out: got %h want 0060", i, out); end
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold%0d_valid: got %b want 0", i, out_valid); end
            n_checks++;
            if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
                n_fail++; $display("FAIL hold%0d_flags: got %b want 0000", i, {flag_z, flag_c, flag_n, flag_v});
            end
        end
    endtask

    task automatic test_reset_with_valid();
        drive(1'b1, 3'd7, 16'h0F0F, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; opcode = 3'd0; a = 16'd1; b = 16'd1;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 16'h0000) begin n_fail++; $display("FAIL rstv_out: got %h want 0000", out); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstv_valid: got %b want 0", out_valid); end
        n_checks++;
        if ({flag_z, flag_c, flag_n, flag_v} !== 4'b0000) begin
            n_fail++; $display("FAIL rstv_flags: got %b want 0000", {flag_z, flag_c, flag_n, flag_v});
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; opcode = 3'd0; a = 16'd2; b = 16'd3;
        @(posedge clk); #1;
        n_checks++;
        if (out !== 16'd5 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_op: got %h/%b want 0005/1", out, out_valid);
        end
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [15:0] exp_out, r;
        logic [3:0]  exp_f, f;
        logic        v;
        logic [2:0]  op;
        logic [15:0] av, bv;
        exp_out = 16'h0; exp_f = 4'h0;
        for (int i = 0; i < 300; i++) begin
            v  = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            av = pick_operand();
            bv = pick_operand();
            drive(v, op, av, bv);
            if (v) begin
                model(op, av, bv, r, f);
                exp_out = r; exp_f = f;
            end
            @(posedge clk); #1;
            n_checks++;
            if (out !== exp_out || out_valid !== v || {flag_z, flag_c, flag_n, flag_v} !== exp_f) begin
                n_fail++;
                $display("FAIL rnd%0d op=%0d a=%h b=%h: got %h/%b/%b want %h/%b/%b", i, op, av, bv,
                         out, out_valid, {flag_z, flag_c, flag_n, flag_v}, exp_out, v, exp_f);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = 3'd0;
        a        = 16'h0;
        b        = 16'h0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_with_valid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
